// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: holds the PC, selects the 32-bit instruction from the
// I-cache word and queues {pc, npc, inst} for decode, with redirect and back-pressure.
module if_fetch_stage #(
  parameter int unsigned FETCH_BUF_DEPTH = 4,
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter logic [31:0] NOP_INST        = 32'h47ff041f
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] Icache_data_out,
  input  logic        Icache_valid_out,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  input  logic        decode_ready,
  output logic [63:0] proc2Icache_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc,
  output logic [63:0] if_npc,
  output logic [31:0] fetch_stall_cycles
);

  localparam int unsigned PTR_W = $clog2(FETCH_BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] npc;
    logic [31:0] inst;
  } entry_t;

  logic [63:0]      pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  entry_t           fifo_mem [FETCH_BUF_DEPTH];

  logic        not_full;
  logic        pop;
  logic        push;
  logic        stall_inc;
  logic [31:0] fetch_inst;
  logic [63:0] pc_plus4;
  logic [63:0] redirect_target;
  entry_t      head_entry;

  // Word-aligned lookup address; the cache answers in the same cycle.
  assign proc2Icache_addr = {pc[63:3], 3'b000};
  assign redirect_target  = redirect_pc & ~64'h3;
  assign pc_plus4         = pc + 64'd4;
  assign fetch_inst       = pc[2] ? Icache_data_out[63:32] : Icache_data_out[31:0];

  assign not_full   = count < CNT_W'(FETCH_BUF_DEPTH);
  assign head_entry = fifo_mem[head];
  assign if_valid   = (count != '0);
  assign pop        = if_valid & decode_ready;
  assign push       = Icache_valid_out & ~redirect_en & (not_full | pop);
  // A miss only counts as a stall when there is room to accept the instruction.
  assign stall_inc  = ~Icache_valid_out & not_full & ~redirect_en & (fetch_stall_cycles != '1);

  always_comb begin
    if_inst = NOP_INST;
    if_pc   = 64'h0;
    if_npc  = 64'h0;
    if (if_valid) begin
      if_inst = head_entry.inst;
      if_pc   = head_entry.pc;
      if_npc  = head_entry.npc;
    end
  end

  // PC, FIFO pointers and stall counter; reset beats redirect, redirect beats fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc                 <= RESET_PC;
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      fetch_stall_cycles <= '0;
    end else if (redirect_en) begin
      pc    <= redirect_target;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc   <= pc_plus4;
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (stall_inc) begin
        fetch_stall_cycles <= fetch_stall_cycles + 32'd1;
      end
    end
  end

  // Payload storage needs no reset; contents are masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      fifo_mem[tail] <= '{pc: pc, npc: pc_plus4, inst: fetch_inst};
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a queue-based reference model.
module tb_if_fetch_stage;

  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RST_PC = 64'h0;
  localparam logic [31:0] NOP    = 32'h47ff041f;
  localparam logic [63:0] D      = 64'hAAAA_BBBB_CCCC_DDDD;

  logic        clock;
  logic        reset;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        decode_ready;
  logic [63:0] proc2Icache_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic [63:0] if_npc;
  logic [31:0] fetch_stall_cycles;

  int total = 0;
  int bad   = 0;

  if_fetch_stage #(
    .FETCH_BUF_DEPTH(DEPTH),
    .RESET_PC(RST_PC),
    .NOP_INST(NOP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .Icache_data_out(Icache_data_out),
    .Icache_valid_out(Icache_valid_out),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .decode_ready(decode_ready),
    .proc2Icache_addr(proc2Icache_addr),
    .if_valid(if_valid),
    .if_inst(if_inst),
    .if_pc(if_pc),
    .if_npc(if_npc),
    .fetch_stall_cycles(fetch_stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: the fetch buffer is just a queue of {pc, inst}.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc    = RST_PC;
  logic [31:0] m_stall = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    logic        v;
    logic [63:0] ep;
    v  = (mq.size() != 0);
    ep = v ? mq[0].pc : 64'h0;
    chk("model_addr", proc2Icache_addr, m_pc & ~64'h7);
    chk("model_valid", 64'(if_valid), 64'(v));
    chk("model_inst", 64'(if_inst), 64'(v ? mq[0].inst : NOP));
    chk("model_pc", if_pc, ep);
    chk("model_npc", if_npc, v ? ep + 64'd4 : 64'h0);
    chk("model_stall", 64'(fetch_stall_cycles), 64'(m_stall));
  endtask

  task automatic model_step();
    bit pop_now;
    bit push_now;
    if (reset) begin
      mq.delete();
      m_pc    = RST_PC;
      m_stall = 32'h0;
    end else if (redirect_en) begin
      mq.delete();
      m_pc = {redirect_pc[63:2], 2'b00};
    end else begin
      pop_now  = (mq.size() > 0) && decode_ready;
      push_now = Icache_valid_out && ((mq.size() < DEPTH) || pop_now);
      if (!Icache_valid_out && mq.size() < DEPTH && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (pop_now) void'(mq.pop_front());
      if (push_now) begin
        mq.push_back('{pc: m_pc, inst: m_pc[2] ? Icache_data_out[63:32] : Icache_data_out[31:0]});
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic hv, input logic [63:0] data,
                       input logic re, input logic [63:0] rpc, input logic dr);
    reset            = rst;
    Icache_valid_out = hv;
    Icache_data_out  = data;
    redirect_en      = re;
    redirect_pc      = rpc;
    decode_ready     = dr;
  endtask

  task automatic finish_cycle(input bit do_check);
    if (do_check) model_compare();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic cycle(input logic rst, input logic hv, input logic [63:0] data,
                       input logic re, input logic [63:0] rpc, input logic dr);
    drive(rst, hv, data, re, rpc, dr);
    #3;
    finish_cycle(1'b1);
  endtask

  typedef struct {
    logic        rst;
    logic        hv;
    logic        re;
    logic [63:0] rpc;
    logic        dr;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic [31:0] e_stall;
  } vec_t;

  vec_t vt[10];

  initial begin
    // rst hv re rpc dr | addr valid inst pc stall  (outputs seen before the row's edge)
    vt[0] = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 64'h0,    1'b0, NOP,          64'h0,    32'd0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 64'h0,    1'b1, 32'hCCCC_DDDD, 64'h0,    32'd0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 64'h8,    1'b1, 32'hAAAA_BBBB, 64'h4,    32'd0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 64'h8,    1'b1, 32'hCCCC_DDDD, 64'h8,    32'd0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 64'h8,    1'b0, NOP,          64'h0,    32'd1};
    vt[5] = '{1'b0, 1'b1, 1'b1, 64'h1007, 1'b0, 64'h8,    1'b0, NOP,          64'h0,    32'd2};
    vt[6] = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b0, 64'h1000, 1'b0, NOP,          64'h0,    32'd2};
    vt[7] = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b0, 64'h1008, 1'b1, 32'hAAAA_BBBB, 64'h1004, 32'd2};
    vt[8] = '{1'b1, 1'b1, 1'b1, 64'h2000, 1'b1, 64'h1008, 1'b1, 32'hAAAA_BBBB, 64'h1004, 32'd2};
    vt[9] = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0, NOP,          64'h0,    32'd0};

    // Initial reset; outputs are undefined before the first edge.
    drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    #3;
    finish_cycle(1'b0);

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].rst, vt[i].hv, D, vt[i].re, vt[i].rpc, vt[i].dr);
      #3;
      chk($sformatf("vec%0d_addr", i), proc2Icache_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 64'(if_valid), 64'(vt[i].e_valid));
      chk($sformatf("vec%0d_inst", i), 64'(if_inst), 64'(vt[i].e_inst));
      chk($sformatf("vec%0d_pc", i), if_pc, vt[i].e_pc);
      chk($sformatf("vec%0d_stall", i), 64'(fetch_stall_cycles), 64'(vt[i].e_stall));
      finish_cycle(1'b1);
    end

    // Back-pressure: six hits with decode stalled, then drain with simultaneous push/pop.
    cycle(1'b1, 1'b0, D, 1'b0, 64'h0, 1'b0);
    repeat (6) cycle(1'b0, 1'b1, D, 1'b0, 64'h0, 1'b0);
    chk("bp_addr_hold", proc2Icache_addr, 64'h10);
    chk("bp_stall_zero", 64'(fetch_stall_cycles), 64'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_drain%0d_pc", k), if_pc, 64'(k * 4));
      cycle(1'b0, 1'b1, D, 1'b0, 64'h0, 1'b1);
    end
    chk("full_pushpop_next_pc", if_pc, 64'h10);
    chk("full_pushpop_addr", proc2Icache_addr, 64'h20);

    // Miss at pc 0x40 for five cycles.
    cycle(1'b1, 1'b0, D, 1'b0, 64'h0, 1'b0);
    repeat (16) cycle(1'b0, 1'b1, D, 1'b0, 64'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("miss%0d_addr", k), proc2Icache_addr, 64'h40);
      cycle(1'b0, 1'b0, D, 1'b0, 64'h0, 1'b1);
    end
    chk("miss_stall_count", 64'(fetch_stall_cycles), 64'd5);
    cycle(1'b0, 1'b1, D, 1'b0, 64'h0, 1'b1);
    chk("miss_fill_pc", if_pc, 64'h40);
    chk("miss_fill_inst", 64'(if_inst), 64'hCCCC_DDDD);

    // Redirect with a full FIFO and a hit present.
    cycle(1'b1, 1'b0, D, 1'b0, 64'h0, 1'b0);
    repeat (4) cycle(1'b0, 1'b1, D, 1'b0, 64'h0, 1'b0);
    cycle(1'b0, 1'b1, D, 1'b1, 64'h1007, 1'b1);
    chk("redir_valid", 64'(if_valid), 64'h0);
    chk("redir_addr", proc2Icache_addr, 64'h1000);
    cycle(1'b0, 1'b1, D, 1'b0, 64'h0, 1'b0);
    chk("redir_first_pc", if_pc, 64'h1004);
    chk("redir_first_inst", 64'(if_inst), 64'hAAAA_BBBB);
    chk("redir_first_npc", if_npc, 64'h1008);

    // Reset mid-stream with three entries buffered and a redirect pending.
    cycle(1'b0, 1'b0, D, 1'b0, 64'h0, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, D, 1'b0, 64'h0, 1'b0);
    cycle(1'b1, 1'b1, D, 1'b1, 64'h2000, 1'b1);
    chk("rst_mid_addr", proc2Icache_addr, RST_PC);
    chk("rst_mid_valid", 64'(if_valid), 64'h0);
    chk("rst_mid_inst", 64'(if_inst), 64'(NOP));
    chk("rst_mid_stall", 64'(fetch_stall_cycles), 64'h0);

    // Randomized traffic with phases that bias decode toward stalling or draining.
    for (int n = 0; n < 1500; n++) begin
      logic        r_rst;
      logic        r_hv;
      logic        r_re;
      logic        r_dr;
      logic [63:0] r_data;
      logic [63:0] r_rpc;
      r_rst  = ($urandom_range(0, 199) == 0);
      r_hv   = ($urandom_range(0, 3) != 0);
      r_re   = ($urandom_range(0, 39) == 0);
      r_dr   = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      r_data = {$urandom, $urandom};
      r_rpc  = {$urandom, $urandom};
      cycle(r_rst, r_hv, r_data, r_re, r_rpc, r_dr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
